// File: rtl/my_dut_pkg.sv
// Shared constants, select-width helper and field typedefs for the my_dut nibble selector.
package my_dut_pkg;

    localparam int DATA_W_DEF      = 16;
    localparam int NIB_W_DEF       = 4;
    localparam int DEFAULT_SEL_DEF = 1;

    // Width of a field index; at least one bit even when there is a single field.
    function automatic int sel_width(input int data_w, input int nib_w);
        int n;
        n = data_w / nib_w;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int SEL_W_DEF = sel_width(DATA_W_DEF, NIB_W_DEF);

    typedef logic [NIB_W_DEF-1:0] nibble_t;
    typedef logic [SEL_W_DEF-1:0] sel_t;

endpackage

// File: rtl/my_dut_nib_mux.sv
// Combinational indexed field mux; an index past the last field yields zero.
module my_dut_nib_mux
    import my_dut_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NIB_W  = NIB_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]  sel,
    output logic [NIB_W-1:0]  nib
);

    localparam int NUM_NIB = DATA_W / NIB_W;

    always_comb begin
        nib = '0;
        for (int i = 0; i < NUM_NIB; i++) begin
            if (sel == SEL_W'(i)) begin
                nib = data_in[i*NIB_W +: NIB_W];
            end
        end
    end

endmodule

// File: rtl/my_dut.sv
// Registered nibble selector with run-time programmable field index.
// Optional MY_DUT_PARITY_EN adds a registered even-parity output of the captured field.
module my_dut
    import my_dut_pkg::*;
#(
    parameter int  DATA_W      = DATA_W_DEF,
    parameter int  NIB_W       = NIB_W_DEF,
    parameter int  DEFAULT_SEL = DEFAULT_SEL_DEF,
    localparam int SEL_W       = sel_width(DATA_W, NIB_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              en,
    input  logic              sel_we,
    input  logic [SEL_W-1:0]  sel_in,
    output logic [NIB_W-1:0]  data_out,
    output logic              valid_out,
    output logic [SEL_W-1:0]  sel_q
`ifdef MY_DUT_PARITY_EN
    ,
    output logic              parity_out
`endif
);

    generate
        if (DATA_W % NIB_W != 0) begin : g_bad_width
            $error("my_dut: DATA_W must be a multiple of NIB_W");
        end
        if (DEFAULT_SEL >= DATA_W / NIB_W) begin : g_bad_default
            $error("my_dut: DEFAULT_SEL must be below DATA_W/NIB_W");
        end
    endgenerate

    logic [NIB_W-1:0] nib_p0;
    logic [NIB_W-1:0] data_p1;
    logic             vld_p1;

    my_dut_nib_mux #(
        .DATA_W (DATA_W),
        .NIB_W  (NIB_W),
        .SEL_W  (SEL_W)
    ) u_nib_mux (
        .data_in (data_in),
        .sel     (sel_q),
        .nib     (nib_p0)
    );

    // p0 -> p1: capture the selected field; a select write lands after this edge's capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            sel_q   <= SEL_W'(DEFAULT_SEL);
        end else begin
            vld_p1 <= en;
            if (en) begin
                data_p1 <= nib_p0;
            end
            if (sel_we) begin
                sel_q <= sel_in;
            end
        end
    end

    assign data_out  = data_p1;
    assign valid_out = vld_p1;

`ifdef MY_DUT_PARITY_EN
    logic parity_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_p1 <= 1'b0;
        end else if (en) begin
            parity_p1 <= ^nib_p0;
        end
    end

    assign parity_out = parity_p1;
`endif

endmodule

// File: tb/tb_my_dut.sv
// Directed self-checking bench for my_dut (default parameters; parity checks when MY_DUT_PARITY_EN is defined).
module tb_my_dut;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic        en;
    logic        sel_we;
    logic [1:0]  sel_in;
    logic [3:0]  data_out;
    logic        valid_out;
    logic [1:0]  sel_q;
`ifdef MY_DUT_PARITY_EN
    logic        parity_out;
`endif

    int checks   = 0;
    int failures = 0;

    my_dut dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .en        (en),
        .sel_we    (sel_we),
        .sel_in    (sel_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .sel_q     (sel_q)
`ifdef MY_DUT_PARITY_EN
        ,
        .parity_out(parity_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b1;
        en      = 1'b0;
        sel_we  = 1'b0;
        sel_in  = 2'd0;
        data_in = 16'h0000;

        // Reset asserted mid-cycle takes effect without a clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data",  data_out,  4'h0);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_sel",   sel_q,     2'd1);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_data",  data_out,  4'h0);
        chk("idle_valid", valid_out, 1'b0);
        chk("idle_sel",   sel_q,     2'd1);

        // Default select: nibble 1
        en = 1'b1; data_in = 16'h00AA;
        tick();
        chk("def_aa_data",  data_out,  4'hA);
        chk("def_aa_valid", valid_out, 1'b1);
        data_in = 16'h00F0;
        tick();
        chk("def_f0_data", data_out, 4'hF);

        // Reprogram: capture on the write edge still uses the old select
        sel_we = 1'b1; sel_in = 2'd3; data_in = 16'hC0F0;
        tick();
        chk("wr_edge_data", data_out, 4'hF);
        chk("wr_edge_sel",  sel_q,    2'd3);
        sel_we = 1'b0;
        tick();
        chk("sel3_data", data_out, 4'hC);
        sel_we = 1'b1; sel_in = 2'd0;
        tick();
        chk("wr0_edge_data", data_out, 4'hC);
        sel_we = 1'b0;
        tick();
        chk("sel0_data", data_out, 4'h0);
        chk("sel0_sel",  sel_q,    2'd0);

        // Hold with en low
        data_in = 16'h000A;
        tick();
        chk("hold_cap", data_out, 4'hA);
        en = 1'b0; data_in = 16'hFFFF;
        tick();
        chk("hold_data",  data_out,  4'hA);
        chk("hold_valid", valid_out, 1'b0);
        tick();
        chk("hold2_data", data_out, 4'hA);

        // Reset mid-operation with select 3 and a captured 4'hC
        en = 1'b1; sel_we = 1'b1; sel_in = 2'd3; data_in = 16'hC000;
        tick();
        sel_we = 1'b0;
        tick();
        chk("pre_rst_data", data_out, 4'hC);
        chk("pre_rst_sel",  sel_q,    2'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_data",  data_out,  4'h0);
        chk("mid_rst_valid", valid_out, 1'b0);
        chk("mid_rst_sel",   sel_q,     2'd1);
        sel_we = 1'b1; sel_in = 2'd2;
        tick();
        chk("rst_hold_data", data_out, 4'h0);
        chk("rst_hold_sel",  sel_q,    2'd1);
        sel_we = 1'b0; data_in = 16'h0050;
        rst_n = 1'b1;
        tick();
        chk("post_rst_data",  data_out,  4'h5);
        chk("post_rst_valid", valid_out, 1'b1);

`ifdef MY_DUT_PARITY_EN
        data_in = 16'h0070;
        tick();
        chk("par_7_data", data_out,   4'h7);
        chk("par_7",      parity_out, 1'b1);
        data_in = 16'h00F0;
        tick();
        chk("par_f", parity_out, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
